// File: rtl/ovc_state_ctrl.sv
// Output-VC state and credit controller.
// Each downstream VC k runs its own IDLE/ACTIVE/DRAIN machine and credit counter. The
// availability vector feeds VC allocation and the credit-ok vector feeds switch allocation.
// All outputs are registered, so an update at edge t is visible from cycle t+1.
module ovc_state_ctrl #(
    parameter int unsigned N     = 5,
    parameter int unsigned V     = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*V-1:0]    va_grant_i,
    input  logic [N*V-1:0]    flit_sent_i,
    input  logic [N*V-1:0]    tail_sent_i,
    input  logic [N*V-1:0]    credit_ret_i,
    output logic [N*V-1:0]    ovc_avail_o,
    output logic [N*V-1:0]    ovc_credit_ok_o,
    output logic [N*V*CW-1:0] ovc_credit_o,
    output logic              err_o
);

    localparam int unsigned   NV        = N * V;
    localparam logic [CW-1:0] CreditMax = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDrain
    } vc_state_e;

    vc_state_e     state_q  [NV];
    vc_state_e     state_d  [NV];
    logic [CW-1:0] credit_q [NV];
    logic [CW-1:0] credit_d [NV];
    logic [NV-1:0] vc_err;
    logic [NV-1:0] avail_q, avail_d;
    logic [NV-1:0] ok_q, ok_d;
    logic          err_q, err_d;

    // Per-VC next credit count, next state and protocol-error detection.
    always_comb begin
        for (int unsigned k = 0; k < NV; k++) begin
            credit_d[k] = credit_q[k];
            state_d[k]  = state_q[k];
            vc_err[k]   = 1'b0;

            // A send and a return in the same cycle cancel out.
            if (flit_sent_i[k] && !credit_ret_i[k]) begin
                if (credit_q[k] == '0) begin
                    vc_err[k] = 1'b1;
                end else begin
                    credit_d[k] = credit_q[k] - 1'b1;
                end
            end else if (credit_ret_i[k] && !flit_sent_i[k]) begin
                if (credit_q[k] == CreditMax) begin
                    vc_err[k] = 1'b1;
                end else begin
                    credit_d[k] = credit_q[k] + 1'b1;
                end
            end

            if (tail_sent_i[k] && !flit_sent_i[k]) begin
                vc_err[k] = 1'b1;
            end

            case (state_q[k])
                StIdle: begin
                    if (flit_sent_i[k]) vc_err[k] = 1'b1;
                    if (va_grant_i[k])  state_d[k] = StActive;
                end
                StActive: begin
                    if (va_grant_i[k]) vc_err[k] = 1'b1;
                    if (flit_sent_i[k] && tail_sent_i[k]) state_d[k] = StDrain;
                end
                StDrain: begin
                    if (va_grant_i[k] || flit_sent_i[k]) vc_err[k] = 1'b1;
                    // Exit once every downstream slot is free again (post-update count).
                    if (credit_d[k] == CreditMax) state_d[k] = StIdle;
                end
                default: state_d[k] = StIdle;
            endcase

            avail_d[k] = (state_d[k] == StIdle);
            ok_d[k]    = (credit_d[k] != '0);
        end
        err_d = err_q | (|vc_err);
    end

    // State, credit and output registers; reset discards any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NV; k++) begin
                state_q[k]  <= StIdle;
                credit_q[k] <= CreditMax;
            end
            avail_q <= '1;
            ok_q    <= '1;
            err_q   <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NV; k++) begin
                state_q[k]  <= state_d[k];
                credit_q[k] <= credit_d[k];
            end
            avail_q <= avail_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    // Flatten the credit counters onto the output bus.
    always_comb begin
        ovc_credit_o = '0;
        for (int unsigned k = 0; k < NV; k++) begin
            ovc_credit_o[k*CW +: CW] = credit_q[k];
        end
    end

    assign ovc_avail_o     = avail_q;
    assign ovc_credit_ok_o = ok_q;
    assign err_o           = err_q;

endmodule
